// File: rtl/blake2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : blake2_pkg
// Description : Shared definitions for the BLAKE2 block feeder and hash core:
//               feeder FSM state type and default word/block geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package blake2_pkg;

    // Default word width in bits and bytes per compression block.
    localparam int BLAKE2_W  = 64;
    localparam int BLAKE2_BB = BLAKE2_W * 2;

    // Feeder sequencing states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        KEY       = 3'd1,
        MSG       = 3'd2,
        PAD       = 3'd3,
        WAIT_HASH = 3'd4
    } e_feed_fsm;

endpackage : blake2_pkg
`default_nettype wire

// File: rtl/blake2_feeder.sv
`default_nettype none
// ============================================================================
// Module      : blake2_feeder
// Description : Turns a BLAKE2 command (key length, digest length, message
//               length) plus an upstream byte stream into a block-framed byte
//               stream for the hash core. The key, if any, occupies a whole
//               zero-padded block; the message is zero-padded to a block
//               boundary; an empty unkeyed message becomes one zero block.
//               After the last block, digest-byte strobes from the core are
//               counted and done_o pulses once nn bytes have been returned.
// Ports       :
//   clk, reset                 single clock, synchronous active-high reset
//   cmd_v_i/cmd_ready_o        command handshake (kk, nn, ll); err_o pulses
//                              when an illegal command is dropped
//   s_v_i/s_ready_o/s_data_i   upstream bytes: kk key bytes then ll bytes
//   core_ready_i, data_v_o,    zero-latency byte transfer to the core with
//   data_idx_o, data_o,        in-block index and first/last block flags
//   block_first_o/_last_o
//   kk_o, nn_o, ll_o           latched command parameters (ll_o includes the
//                              key block length when keyed)
//   h_v_i, done_o              digest-byte strobe in, completion pulse out
// Revision    : 1.0 - initial release
// ============================================================================
module blake2_feeder
    import blake2_pkg::*;
#(
    parameter  int W    = BLAKE2_W,
    parameter  int BB   = W * 2,
    parameter  int LL_W = 64,
    localparam int KW   = $clog2(W + 1),
    localparam int IW   = $clog2(BB)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_v_i,
    output logic            cmd_ready_o,
    input  logic [KW-1:0]   cmd_kk_i,
    input  logic [KW-1:0]   cmd_nn_i,
    input  logic [LL_W-1:0] cmd_ll_i,
    output logic            err_o,
    input  logic            s_v_i,
    output logic            s_ready_o,
    input  logic [7:0]      s_data_i,
    input  logic            core_ready_i,
    output logic            data_v_o,
    output logic [IW-1:0]   data_idx_o,
    output logic [7:0]      data_o,
    output logic            block_first_o,
    output logic            block_last_o,
    output logic [KW-1:0]   kk_o,
    output logic [KW-1:0]   nn_o,
    output logic [BB-1:0]   ll_o,
    input  logic            h_v_i,
    output logic            done_o
);

    localparam logic [IW-1:0]   IDX_LAST = IW'(BB - 1);
    localparam logic [LL_W-1:0] BB_LL    = LL_W'(BB);
    localparam logic [KW-1:0]   W_KW     = KW'(W);

    e_feed_fsm       state;
    e_feed_fsm       state_nxt;
    logic [IW-1:0]   idx;
    logic [LL_W-1:0] rem;
    logic [LL_W-1:0] rem_after;
    logic [KW-1:0]   key_cnt;
    logic [KW-1:0]   hash_cnt;
    logic            first_blk;
    logic            last_blk;
    logic            cmd_bad;
    logic            accept;
    logic            drop;
    logic            hash_hit;
    logic            blk_end;

    assign cmd_bad   = (cmd_nn_i == '0) || (cmd_nn_i > W_KW) || (cmd_kk_i > W_KW);
    assign blk_end   = data_v_o && (idx == IDX_LAST);
    // Bytes still owed after the current transfer; only MSG consumes them.
    assign rem_after = (state == MSG) ? rem - LL_W'(1) : rem;

    assign data_idx_o    = idx;
    assign block_first_o = first_blk;
    assign block_last_o  = last_blk;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cmd_ready_o = 1'b0;
        s_ready_o   = 1'b0;
        data_v_o    = 1'b0;
        data_o      = 8'h00;
        accept      = 1'b0;
        drop        = 1'b0;
        hash_hit    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_v_i) begin
                    if (cmd_bad) begin
                        drop = 1'b1;
                    end else begin
                        accept = 1'b1;
                        if (cmd_kk_i != '0) begin
                            state_nxt = KEY;
                        end else if (cmd_ll_i != '0) begin
                            state_nxt = MSG;
                        end else begin
                            state_nxt = PAD;
                        end
                    end
                end
            end
            KEY: begin
                s_ready_o = core_ready_i;
                data_v_o  = s_v_i & core_ready_i;
                data_o    = s_data_i;
                // kk <= W < BB, so the key never fills its block.
                if (data_v_o && (key_cnt == kk_o - KW'(1))) begin
                    state_nxt = PAD;
                end
            end
            MSG: begin
                s_ready_o = core_ready_i;
                data_v_o  = s_v_i & core_ready_i;
                data_o    = s_data_i;
                if (data_v_o && (rem == LL_W'(1))) begin
                    state_nxt = (idx == IDX_LAST) ? WAIT_HASH : PAD;
                end
            end
            PAD: begin
                data_v_o = core_ready_i;
                // Leaving a non-last padded block only happens after the key block.
                if (blk_end) begin
                    state_nxt = last_blk ? WAIT_HASH : MSG;
                end
            end
            WAIT_HASH: begin
                if (h_v_i && (hash_cnt == nn_o - KW'(1))) begin
                    hash_hit  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= '0;
            rem       <= '0;
            key_cnt   <= '0;
            hash_cnt  <= '0;
            first_blk <= 1'b0;
            last_blk  <= 1'b0;
            kk_o      <= '0;
            nn_o      <= '0;
            ll_o      <= '0;
            err_o     <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            err_o  <= drop;
            done_o <= hash_hit;
            if (accept) begin
                kk_o      <= cmd_kk_i;
                nn_o      <= cmd_nn_i;
                ll_o      <= BB'(cmd_ll_i) + ((cmd_kk_i != '0) ? BB'(BB) : '0);
                idx       <= '0;
                rem       <= cmd_ll_i;
                key_cnt   <= '0;
                hash_cnt  <= '0;
                first_blk <= 1'b1;
                // Keyed: key block is last only with no message.
                // Unkeyed: first message block (or the empty block).
                last_blk  <= (cmd_kk_i != '0) ? (cmd_ll_i == '0) : (cmd_ll_i <= BB_LL);
            end
            if (data_v_o) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
                if (state == KEY) begin
                    key_cnt <= key_cnt + KW'(1);
                end
                if (state == MSG) begin
                    rem <= rem_after;
                end
            end
            // The next block always starts at idx 0, so it is last when the
            // outstanding bytes fit in one block.
            if (blk_end) begin
                first_blk <= 1'b0;
                last_blk  <= (rem_after <= BB_LL);
            end
            if ((state == WAIT_HASH) && h_v_i) begin
                hash_cnt <= hash_cnt + KW'(1);
            end
        end
    end

endmodule : blake2_feeder
`default_nettype wire

// File: tb/tb_blake2_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_blake2_feeder
// Description : Self-checking bench for blake2_feeder. Each transaction's
//               expected core-side byte stream is built from the block
//               framing rules (key block, padded message blocks, empty block)
//               and compared byte by byte under random back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blake2_feeder;

    localparam int W    = 64;
    localparam int BB   = 128;
    localparam int LL_W = 64;
    localparam int KW   = 7;
    localparam int IW   = 7;

    typedef struct {
        logic [7:0] d;
        bit         from_s;
        int         idx;
        bit         first;
        bit         last;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cmd_v_i = 1'b0;
    logic            cmd_ready_o;
    logic [KW-1:0]   cmd_kk_i = '0;
    logic [KW-1:0]   cmd_nn_i = '0;
    logic [LL_W-1:0] cmd_ll_i = '0;
    logic            err_o;
    logic            s_v_i = 1'b0;
    logic            s_ready_o;
    logic [7:0]      s_data_i = '0;
    logic            core_ready_i = 1'b0;
    logic            data_v_o;
    logic [IW-1:0]   data_idx_o;
    logic [7:0]      data_o;
    logic            block_first_o;
    logic            block_last_o;
    logic [KW-1:0]   kk_o;
    logic [KW-1:0]   nn_o;
    logic [BB-1:0]   ll_o;
    logic            h_v_i = 1'b0;
    logic            done_o;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    blake2_feeder #(.W(W), .BB(BB), .LL_W(LL_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_v_i       (cmd_v_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_kk_i      (cmd_kk_i),
        .cmd_nn_i      (cmd_nn_i),
        .cmd_ll_i      (cmd_ll_i),
        .err_o         (err_o),
        .s_v_i         (s_v_i),
        .s_ready_o     (s_ready_o),
        .s_data_i      (s_data_i),
        .core_ready_i  (core_ready_i),
        .data_v_o      (data_v_o),
        .data_idx_o    (data_idx_o),
        .data_o        (data_o),
        .block_first_o (block_first_o),
        .block_last_o  (block_last_o),
        .kk_o          (kk_o),
        .nn_o          (nn_o),
        .ll_o          (ll_o),
        .h_v_i         (h_v_i),
        .done_o        (done_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Idle-side checks after a reset (entered and left at posedge+1).
    task automatic chk_reset_state(input string tag);
        @(negedge clk);
        chk({tag, "_cmd_ready"}, cmd_ready_o, 1);
        chk({tag, "_data_v"}, data_v_o, 0);
        chk({tag, "_s_ready"}, s_ready_o, 0);
        chk({tag, "_kk"}, kk_o, 0);
        chk({tag, "_nn"}, nn_o, 0);
        chk({tag, "_ll"}, ll_o, 0);
        chk({tag, "_first"}, block_first_o, 0);
        chk({tag, "_last"}, block_last_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_err"}, err_o, 0);
        @(posedge clk); #1;
    endtask

    // Illegal command: dropped with a one-cycle err_o pulse, no transfers.
    task automatic bad_cmd(input int kk, input int nn, input int ll);
        cmd_v_i = 1'b1; cmd_kk_i = KW'(kk); cmd_nn_i = KW'(nn); cmd_ll_i = LL_W'(ll);
        core_ready_i = 1'b1; s_v_i = 1'b1;
        @(negedge clk);
        chk("bad_cmd_ready", cmd_ready_o, 1);
        @(posedge clk); #1;
        cmd_v_i = 1'b0;
        @(negedge clk);
        chk("bad_err_pulse", err_o, 1);
        chk("bad_cmd_ready_after", cmd_ready_o, 1);
        chk("bad_data_v", data_v_o, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bad_err_clear", err_o, 0);
        chk("bad_data_v2", data_v_o, 0);
        chk("bad_idle", cmd_ready_o, 1);
        @(posedge clk); #1;
    endtask

    // One full command. stall_at: byte position where core_ready_i is held
    // low for 20 cycles. abort_at: byte position where reset is applied.
    task automatic run_txn(input int kk, input int nn, input int ll,
                           input int stall_at, input int abort_at);
        logic [7:0] src[$];
        exp_t       q[$];
        exp_t       e;
        int nblk, base, pos, cyc, bound, stall_left, hv;
        bit stalled, cr, sv, ev, h;
        logic [127:0] exp_ll;

        for (int i = 0; i < kk + ll; i++) src.push_back(8'($urandom));
        base = (kk > 0) ? 1 : 0;
        nblk = base + (ll + BB - 1) / BB;
        if (nblk == 0) nblk = 1;
        for (int p = 0; p < nblk * BB; p++) begin
            if (base == 1 && p < BB) begin
                e.from_s = (p < kk);
                e.d      = (p < kk) ? src[p] : 8'h00;
            end else begin
                int m;
                m = p - base * BB;
                e.from_s = (m < ll);
                e.d      = (m < ll) ? src[kk + m] : 8'h00;
            end
            e.idx   = p % BB;
            e.first = (p < BB);
            e.last  = (p >= (nblk - 1) * BB);
            q.push_back(e);
        end
        exp_ll = 128'(ll) + ((kk > 0) ? 128'(BB) : 128'd0);

        cmd_v_i = 1'b1; cmd_kk_i = KW'(kk); cmd_nn_i = KW'(nn); cmd_ll_i = LL_W'(ll);
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready_o, 1);
        @(posedge clk); #1;

        pos = 0; cyc = 0; stall_left = 0; stalled = 0;
        bound = q.size() * 30 + 200;
        while (pos < q.size() && cyc < bound) begin
            if (abort_at >= 0 && pos == abort_at) begin
                reset = 1'b1; core_ready_i = 1'b1; s_v_i = 1'b1; cmd_v_i = 1'b0;
                @(posedge clk); #1;
                reset = 1'b0;
                chk_reset_state("abort");
                return;
            end
            if (pos == stall_at && !stalled) begin
                stalled = 1; stall_left = 20;
            end
            cr = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
            sv = ($urandom_range(0, 3) != 0);
            core_ready_i = cr;
            s_v_i        = sv;
            s_data_i     = q[pos].from_s ? q[pos].d : 8'($urandom);
            // Commands and digest strobes outside their states must be ignored.
            cmd_v_i  = 1'($urandom_range(0, 1));
            cmd_kk_i = KW'($urandom); cmd_nn_i = KW'($urandom); cmd_ll_i = LL_W'($urandom);
            h_v_i    = 1'($urandom_range(0, 1));
            @(negedge clk);
            ev = cr && (q[pos].from_s ? sv : 1'b1);
            chk("data_v", data_v_o, ev);
            chk("s_ready", s_ready_o, cr && q[pos].from_s);
            chk("cmd_ready_busy", cmd_ready_o, 0);
            chk("err_busy", err_o, 0);
            chk("done_busy", done_o, 0);
            chk("kk_hold", kk_o, kk);
            chk("nn_hold", nn_o, nn);
            chk("ll_hold", ll_o, exp_ll);
            if (ev && data_v_o) begin
                chk("data", data_o, q[pos].d);
                chk("idx", data_idx_o, q[pos].idx);
                chk("first", block_first_o, q[pos].first);
                chk("last", block_last_o, q[pos].last);
                pos++;
            end
            if (stall_left > 0) stall_left--;
            @(posedge clk); #1;
            cyc++;
        end
        chk("byte_count", pos, q.size());

        cmd_v_i = 1'b0; s_v_i = 1'b0;
        hv = 0; cyc = 0;
        while (hv < nn && cyc < 1000) begin
            h = 1'($urandom_range(0, 1));
            h_v_i = h;
            core_ready_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("hash_data_v", data_v_o, 0);
            chk("hash_done_early", done_o, 0);
            @(posedge clk); #1;
            if (h) hv++;
            cyc++;
        end
        h_v_i = 1'b0;
        chk("hash_count", hv, nn);
        @(negedge clk);
        chk("done_pulse", done_o, 1);
        chk("done_idle", cmd_ready_o, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_clear", done_o, 0);
        chk("post_data_v", data_v_o, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_reset_state("reset");

        run_txn(0, 64, 0, -1, -1);     // empty message: one zero block
        run_txn(0, 32, 3, -1, -1);     // short message padded
        run_txn(0, 20, 128, -1, -1);   // exactly one block, no padding
        run_txn(0, 64, 129, -1, -1);   // one byte spills into second block
        run_txn(32, 64, 3, -1, -1);    // key block followed by message
        run_txn(64, 1, 0, -1, -1);     // full-width key, no message
        run_txn(0, 16, 100, 40, -1);   // long core stall at idx 40
        run_txn(0, 8, 200, -1, 70);    // reset mid-message at idx 70
        bad_cmd(0, 0, 5);
        bad_cmd(0, 65, 5);
        bad_cmd(65, 32, 5);
        for (int t = 0; t < 6; t++) begin
            run_txn($urandom_range(0, 64), $urandom_range(1, 64),
                    $urandom_range(0, 300), -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_blake2_feeder
`default_nettype wire
